// File: rtl/car_lane_renderer.sv
// Car lane renderer: moves NUM_CARS cars once per frame and maps (DrawX, DrawY) to sprite ROM addresses and palette output.
// Latency: rom_addr/collide_row 1 Clk after DrawX/DrawY; car_on/pixel_index 2 Clk after DrawX/DrawY.
// Backpressure: none; tracks the free-running pixel scan every cycle, no stall input.
// Option: defining CAR_LANE_MIRROR_EN flips the sprite horizontally when DIR=1 so cars face left.

module car_lane_renderer #(
  parameter int NUM_CARS = 4,
  parameter int LANE_Y   = 200,
  parameter int SPEED    = 2,
  parameter int DIR      = 0,
  parameter int SPACING  = 170
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        run,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [10:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [3:0]  pixel_index,
  output logic        car_on,
  output logic        collide_row
);

  // Extended x space is [0,680): a car at p covers screen columns p-40 .. p-1.
  localparam logic [10:0] EXT_SPAN  = 11'd680;
  localparam logic [10:0] CAR_W     = 11'd40;
  localparam logic [10:0] STEP      = 11'(SPEED);
  localparam logic [10:0] STEP_BACK = 11'(680 - SPEED);
  localparam logic [9:0]  LANE_TOP  = 10'(LANE_Y);
  localparam logic [9:0]  LANE_BOT  = 10'(LANE_Y + 40);

  function automatic logic [10:0] start_pos(input int idx);
    return 11'((idx * SPACING) % 680);
  endfunction

  logic [10:0] pos_q [NUM_CARS];
  logic [10:0] pos_d [NUM_CARS];
  logic        frame_clk_dly_q, frame_clk_dly_d;
  logic        tick;

  logic [10:0] u;
  logic [10:0] row;
  logic [10:0] col;
  logic        in_lane;
  logic        hit;
  logic [10:0] addr;

  logic [10:0] rom_addr_q, rom_addr_d;
  logic        hit_d1_q, hit_d1_d;
  logic        hit_d2_q, hit_d2_d;
  logic        collide_row_q, collide_row_d;

  // Frame tick edge detect and per-car advance; wrap is a single exact add/subtract of 680.
  always_comb begin
    frame_clk_dly_d = frame_clk;
    tick            = frame_clk & ~frame_clk_dly_q;
    for (int i = 0; i < NUM_CARS; i++) begin
      pos_d[i] = pos_q[i];
      if (tick && run) begin
        if (DIR == 0) begin
          pos_d[i] = (pos_q[i] + STEP >= EXT_SPAN) ? (pos_q[i] + STEP - EXT_SPAN) : (pos_q[i] + STEP);
        end else begin
          pos_d[i] = (pos_q[i] < STEP) ? (pos_q[i] + STEP_BACK) : (pos_q[i] - STEP);
        end
      end
    end
  end

  // Hit test on the pre-update positions; scanning high to low lets the lowest-index car win.
  always_comb begin
    u       = {1'b0, DrawX} + CAR_W;
    row     = {1'b0, DrawY} - {1'b0, LANE_TOP};
    in_lane = (DrawY >= LANE_TOP) && (DrawY < LANE_BOT);
    hit     = 1'b0;
    col     = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (in_lane && (u >= pos_q[i]) && (u < pos_q[i] + CAR_W)) begin
        hit = 1'b1;
        col = u - pos_q[i];
      end
    end
`ifdef CAR_LANE_MIRROR_EN
    if (DIR != 0) begin
      col = 11'd39 - col;
    end
`endif
    addr = hit ? (row * CAR_W + col) : '0;
  end

  // Pipeline next state: address/collision stage, then hit delayed to line up with ROM data.
  always_comb begin
    rom_addr_d    = addr;
    hit_d1_d      = hit;
    collide_row_d = hit;
    hit_d2_d      = hit_d1_q;
  end

  // State registers; reset restores start positions and flushes the pipeline in one cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CARS; i++) begin
        pos_q[i] <= start_pos(i);
      end
      frame_clk_dly_q <= 1'b0;
      rom_addr_q      <= '0;
      hit_d1_q        <= 1'b0;
      hit_d2_q        <= 1'b0;
      collide_row_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CARS; i++) begin
        pos_q[i] <= pos_d[i];
      end
      frame_clk_dly_q <= frame_clk_dly_d;
      rom_addr_q      <= rom_addr_d;
      hit_d1_q        <= hit_d1_d;
      hit_d2_q        <= hit_d2_d;
      collide_row_q   <= collide_row_d;
    end
  end

  // Colour index 0 in the sprite is transparent.
  assign car_on      = hit_d2_q && (rom_data != 4'd0);
  assign pixel_index = car_on ? rom_data : 4'd0;
  assign rom_addr    = rom_addr_q;
  assign collide_row = collide_row_q;

endmodule

// File: tb/tb_car_lane_renderer.sv
// Bench for car_lane_renderer: a right-moving lane (index 0) and a left-moving lane (index 1)
// share all inputs; a position model and a sprite ROM model predict every output.
// Scan expectations are queued at drive time and compared when the pipeline delivers them.

module tb_car_lane_renderer;

  localparam int LANE_Y = 200;

`ifdef CAR_LANE_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]       x;
    logic [9:0]       y;
    logic [1:0]       hit;
    logic [1:0][10:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic        run;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [10:0] rom_addr    [2];
  logic [3:0]  rom_data    [2];
  logic [3:0]  pixel_index [2];
  logic        car_on      [2];
  logic        collide_row [2];

  int   n_vec;
  int   n_bad;
  int   mpos [2][4];
  exp_t s1_q [$];
  exp_t s2_q [$];

  always #5 clk = ~clk;

  car_lane_renderer #(.NUM_CARS(4), .LANE_Y(LANE_Y), .SPEED(2), .DIR(0), .SPACING(170)) dut_r (
    .Clk(clk), .Reset(Reset), .frame_clk(frame_clk), .run(run), .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .pixel_index(pixel_index[0]),
    .car_on(car_on[0]), .collide_row(collide_row[0]));

  car_lane_renderer #(.NUM_CARS(4), .LANE_Y(LANE_Y), .SPEED(2), .DIR(1), .SPACING(231)) dut_l (
    .Clk(clk), .Reset(Reset), .frame_clk(frame_clk), .run(run), .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .pixel_index(pixel_index[1]),
    .car_on(car_on[1]), .collide_row(collide_row[1]));

  // Sprite ROM contents: multiples of 13 are transparent, address 120 holds colour 5.
  function automatic logic [3:0] rom_val(input logic [10:0] a);
    if (a == 11'd120) return 4'd5;
    return 4'(a % 13);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) rom_data[d] <= rom_val(rom_addr[d]);
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mpos[0][i] = (i * 170) % 680;
      mpos[1][i] = (i * 231) % 680;
    end
  endfunction

  function automatic void model_tick();
    for (int i = 0; i < 4; i++) begin
      mpos[0][i] = mpos[0][i] + 2;
      if (mpos[0][i] >= 680) mpos[0][i] = mpos[0][i] - 680;
      mpos[1][i] = mpos[1][i] - 2;
      if (mpos[1][i] < 0) mpos[1][i] = mpos[1][i] + 680;
    end
  endfunction

  function automatic void model_px(input int d, input int x, input int y,
                                   output logic hit, output logic [10:0] addr);
    int u;
    int col;
    u    = x + 40;
    hit  = 1'b0;
    addr = '0;
    if (y >= LANE_Y && y < LANE_Y + 40) begin
      for (int i = 0; i < 4; i++) begin
        if (!hit && u >= mpos[d][i] && u < mpos[d][i] + 40) begin
          hit = 1'b1;
          col = u - mpos[d][i];
          if (MIR && d == 1) col = 39 - col;
          addr = 11'((y - LANE_Y) * 40 + col);
        end
      end
    end
  endfunction

  task automatic frame_tick(input int hold);
    @(negedge clk);
    frame_clk = 1'b1;
    if (run) model_tick();
    repeat (hold) @(negedge clk);
    frame_clk = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_scan(input int y, input int xstep);
    exp_t        e;
    int          n;
    logic        h;
    logic [10:0] a;
    logic [3:0]  pv;
    n = (640 + xstep - 1) / xstep;
    s1_q.delete();
    s2_q.delete();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (s2_q.size() != 0) begin
        e = s2_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          pv = e.hit[d] ? rom_val(e.addr[d]) : 4'd0;
          n_vec++;
          if (car_on[d] !== (pv != 4'd0)) begin
            n_bad++;
            $display("FAIL scan_car_on lane%0d x=%0d y=%0d: got %0b want %0b", d, e.x, e.y, car_on[d], pv != 4'd0);
          end
          n_vec++;
          if (pixel_index[d] !== pv) begin
            n_bad++;
            $display("FAIL scan_pixel lane%0d x=%0d y=%0d: got %0d want %0d", d, e.x, e.y, pixel_index[d], pv);
          end
        end
      end
      if (s1_q.size() != 0) begin
        e = s1_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          n_vec++;
          if (rom_addr[d] !== e.addr[d]) begin
            n_bad++;
            $display("FAIL scan_rom_addr lane%0d x=%0d y=%0d: got %0d want %0d", d, e.x, e.y, rom_addr[d], e.addr[d]);
          end
          n_vec++;
          if (collide_row[d] !== e.hit[d]) begin
            n_bad++;
            $display("FAIL scan_collide lane%0d x=%0d y=%0d: got %0b want %0b", d, e.x, e.y, collide_row[d], e.hit[d]);
          end
        end
        s2_q.push_back(e);
      end
      if (k < n) begin
        DrawX = 10'(k * xstep);
        DrawY = 10'(y);
        e.x   = 10'(k * xstep);
        e.y   = 10'(y);
        for (int d = 0; d < 2; d++) begin
          model_px(d, k * xstep, y, h, a);
          e.hit[d]  = h;
          e.addr[d] = a;
        end
        s1_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    DrawX = '0;
    DrawY = '0;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rom_addr[d] !== 11'd0) begin n_bad++; $display("FAIL reset_rom_addr lane%0d: got %0d want 0", d, rom_addr[d]); end
      n_vec++;
      if (collide_row[d] !== 1'b0) begin n_bad++; $display("FAIL reset_collide lane%0d: got %0b want 0", d, collide_row[d]); end
      n_vec++;
      if (car_on[d] !== 1'b0) begin n_bad++; $display("FAIL reset_car_on lane%0d: got %0b want 0", d, car_on[d]); end
      n_vec++;
      if (pixel_index[d] !== 4'd0) begin n_bad++; $display("FAIL reset_pixel lane%0d: got %0d want 0", d, pixel_index[d]); end
    end
    test_scan(LANE_Y - 1, 4);
    test_scan(LANE_Y, 4);
    test_scan(LANE_Y + 3, 1);
    test_scan(LANE_Y + 39, 4);
    test_scan(LANE_Y + 40, 4);
  endtask

  task automatic test_addr();
    @(negedge clk);
    DrawX = 10'd130;
    DrawY = 10'(LANE_Y + 3);
    @(negedge clk);
    DrawY = 10'd0;
    n_vec++;
    if (rom_addr[0] !== 11'd120) begin n_bad++; $display("FAIL addr_lookup: got %0d want 120", rom_addr[0]); end
    @(negedge clk);
    n_vec++;
    if (car_on[0] !== 1'b1) begin n_bad++; $display("FAIL addr_car_on: got %0b want 1", car_on[0]); end
    n_vec++;
    if (pixel_index[0] !== 4'd5) begin n_bad++; $display("FAIL addr_pixel: got %0d want 5", pixel_index[0]); end
  endtask

  task automatic test_miss();
    int          xs [3] = '{130, 50, 143};
    int          ys [3] = '{LANE_Y + 40, LANE_Y + 3, LANE_Y};
    logic [10:0] ea [3] = '{11'd0, 11'd0, 11'd13};
    logic        ec [3] = '{1'b0, 1'b0, 1'b1};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      DrawX = 10'(xs[j]);
      DrawY = 10'(ys[j]);
      @(negedge clk);
      n_vec++;
      if (rom_addr[0] !== ea[j]) begin n_bad++; $display("FAIL miss_rom_addr case%0d: got %0d want %0d", j, rom_addr[0], ea[j]); end
      n_vec++;
      if (collide_row[0] !== ec[j]) begin n_bad++; $display("FAIL miss_collide case%0d: got %0b want %0b", j, collide_row[0], ec[j]); end
      @(negedge clk);
      n_vec++;
      if (car_on[0] !== 1'b0) begin n_bad++; $display("FAIL miss_car_on case%0d: got %0b want 0", j, car_on[0]); end
      n_vec++;
      if (pixel_index[0] !== 4'd0) begin n_bad++; $display("FAIL miss_pixel case%0d: got %0d want 0", j, pixel_index[0]); end
    end
  endtask

  task automatic test_right_wrap();
    run = 1'b1;
    for (int t = 0; t < 400 && mpos[0][3] != 678; t++) frame_tick(1);
    // Tick and lookup in the same cycle: the lookup sees car 3 still at 678.
    @(negedge clk);
    DrawX     = 10'd638;
    DrawY     = 10'(LANE_Y + 1);
    frame_clk = 1'b1;
    model_tick();
    @(negedge clk);
    n_vec++;
    if (rom_addr[0] !== 11'd40) begin n_bad++; $display("FAIL wrap_pre_update: got %0d want 40", rom_addr[0]); end
    n_vec++;
    if (collide_row[0] !== 1'b1) begin n_bad++; $display("FAIL wrap_pre_collide: got %0b want 1", collide_row[0]); end
    @(negedge clk);
    n_vec++;
    if (rom_addr[0] !== 11'd0) begin n_bad++; $display("FAIL wrap_post_update: got %0d want 0", rom_addr[0]); end
    n_vec++;
    if (collide_row[0] !== 1'b0) begin n_bad++; $display("FAIL wrap_post_collide: got %0b want 0", collide_row[0]); end
    repeat (9) @(negedge clk);
    frame_clk = 1'b0;
    test_scan(LANE_Y, 2);
    test_scan(LANE_Y + 21, 2);
    test_scan(LANE_Y + 39, 2);
  endtask

  task automatic test_left_wrap();
    logic [10:0] want;
    do_reset();
    run = 1'b1;
    for (int t = 0; t < 400 && mpos[1][1] != 1; t++) frame_tick(1);
    frame_tick(1);
    want = MIR ? 11'd239 : 11'd200;
    @(negedge clk);
    DrawX = 10'd639;
    DrawY = 10'(LANE_Y + 5);
    @(negedge clk);
    n_vec++;
    if (rom_addr[1] !== want) begin n_bad++; $display("FAIL left_wrap_addr: got %0d want %0d", rom_addr[1], want); end
    n_vec++;
    if (collide_row[1] !== 1'b1) begin n_bad++; $display("FAIL left_wrap_collide: got %0b want 1", collide_row[1]); end
    run = 1'b0;
    frame_tick(1);
    @(negedge clk);
    n_vec++;
    if (rom_addr[1] !== want) begin n_bad++; $display("FAIL frozen_addr: got %0d want %0d", rom_addr[1], want); end
    run = 1'b1;
    frame_tick(1);
    test_scan(LANE_Y + 5, 1);
    test_scan(LANE_Y + 30, 3);
  endtask

  task automatic test_mirror();
    int          x0;
    logic [10:0] w0;
    logic [10:0] w39;
    x0  = mpos[1][0] - 40;
    w0  = MIR ? 11'd39 : 11'd0;
    w39 = MIR ? 11'd0 : 11'd39;
    @(negedge clk);
    DrawX = 10'(x0);
    DrawY = 10'(LANE_Y);
    @(negedge clk);
    DrawX = 10'(x0 + 39);
    n_vec++;
    if (rom_addr[1] !== w0) begin n_bad++; $display("FAIL mirror_col0: got %0d want %0d", rom_addr[1], w0); end
    n_vec++;
    if (collide_row[1] !== 1'b1) begin n_bad++; $display("FAIL mirror_collide: got %0b want 1", collide_row[1]); end
    @(negedge clk);
    n_vec++;
    if (rom_addr[1] !== w39) begin n_bad++; $display("FAIL mirror_col39: got %0d want %0d", rom_addr[1], w39); end
  endtask

  task automatic test_reset_mid();
    logic        h;
    logic [10:0] a;
    logic [3:0]  pv;
    @(negedge clk);
    DrawX = 10'd130;
    DrawY = 10'(LANE_Y + 3);
    model_px(0, 130, LANE_Y + 3, h, a);
    pv = h ? rom_val(a) : 4'd0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (car_on[0] !== (pv != 4'd0)) begin n_bad++; $display("FAIL pre_reset_car_on: got %0b want %0b", car_on[0], pv != 4'd0); end
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (car_on[d] !== 1'b0) begin n_bad++; $display("FAIL flush1_car_on lane%0d: got %0b want 0", d, car_on[d]); end
      n_vec++;
      if (pixel_index[d] !== 4'd0) begin n_bad++; $display("FAIL flush1_pixel lane%0d: got %0d want 0", d, pixel_index[d]); end
    end
    @(negedge clk);
    n_vec++;
    if (car_on[0] !== 1'b0) begin n_bad++; $display("FAIL flush2_car_on: got %0b want 0", car_on[0]); end
    @(negedge clk);
    n_vec++;
    if (car_on[0] !== 1'b1) begin n_bad++; $display("FAIL after_flush_car_on: got %0b want 1", car_on[0]); end
    n_vec++;
    if (pixel_index[0] !== 4'd5) begin n_bad++; $display("FAIL after_flush_pixel: got %0d want 5", pixel_index[0]); end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    Reset     = 1'b1;
    frame_clk = 1'b0;
    run       = 1'b0;
    DrawX     = '0;
    DrawY     = '0;
    model_reset();
    test_reset();
    test_addr();
    test_miss();
    test_right_wrap();
    test_left_wrap();
    test_mirror();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
